// File: rtl/axis_read_stream.sv
// rtl/axis_read_stream.sv - AXI read-beat buffer and serialiser into length-framed word streams
//
// fifo_simple: show-ahead synchronous FIFO (rd_data_o is the head entry while not empty).
//   clk, rst            clock, synchronous active-high reset
//   wr_en_i, wr_data_i  push (ignored when full)
//   rd_en_i, rd_data_o  pop (ignored when empty), head data
//   empty_o, full_o     occupancy flags
//   almost_full_o       one free entry or fewer left
//
// axis_read_stream: runs queued length commands over buffered AXI read beats.
//   clk, rst                      clock, synchronous active-high reset
//   cfg_length, cfg_val, cfg_rdy  command push (length in DATA_WIDTH words)
//   axi_rdata, axi_rlast          AXI read beat (rlast is buffered but not used for framing)
//   axi_rvalid, axi_rready        AXI read handshake
//   data, last, valid, ready      output word stream, low sub-word of each beat first
//   done                          one-cycle pulse per completed stream
//   busy                          high whenever a command is being processed

module fifo_simple #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [DWIDTH-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DWIDTH-1:0] rd_data_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_full_o
);
  localparam int DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AWIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [AWIDTH:0]   count_q;
  logic              do_wr, do_rd;

  assign empty_o       = (count_q == '0);
  assign full_o        = (count_q == (AWIDTH+1)'(DEPTH));
  assign almost_full_o = (count_q >= (AWIDTH+1)'(DEPTH - 1));
  assign do_wr         = wr_en_i & ~full_o;
  assign do_rd         = rd_en_i & ~empty_o;
  assign rd_data_o     = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AWIDTH'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AWIDTH'(1);
      if (do_wr && !do_rd)      count_q <= count_q + (AWIDTH+1)'(1);
      else if (!do_wr && do_rd) count_q <= count_q - (AWIDTH+1)'(1);
    end
  end
endmodule

module axis_read_stream #(
  parameter int BUF_CFG_AWIDTH = 5,
  parameter int BUF_AWIDTH     = 9,
  parameter int CFG_DWIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WIDTH_RATIO    = 2,
  parameter int AXI_DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CFG_DWIDTH-1:0]     cfg_length,
  input  logic                      cfg_val,
  output logic                      cfg_rdy,
  input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
  input  logic                      axi_rlast,
  input  logic                      axi_rvalid,
  output logic                      axi_rready,
  output logic [DATA_WIDTH-1:0]     data,
  output logic                      last,
  output logic                      valid,
  input  logic                      ready,
  output logic                      done,
  output logic                      busy
);
  localparam int IDX_W = (WIDTH_RATIO > 1) ? $clog2(WIDTH_RATIO) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH_RATIO - 1);

  typedef enum logic [3:0] {
    S_CONFIG = 4'b0001,
    S_SET    = 4'b0010,
    S_ACTIVE = 4'b0100,
    S_FLUSH  = 4'b1000
  } state_t;

  state_t                    state_q;
  logic [CFG_DWIDTH-1:0]     len_q, rem_q, cnt_q;
  logic [IDX_W-1:0]          idx_q;
  logic [AXI_DATA_WIDTH-1:0] beat_q;
  logic                      beat_vld_q;
  logic                      done_q;

  logic [CFG_DWIDTH-1:0]     cmd_data;
  logic                      cmd_empty, cmd_full, cmd_pop;
  logic [AXI_DATA_WIDTH:0]   bfifo_data;
  logic                      bfifo_empty, bfifo_afull, bfifo_pop;
  logic                      cmd_afull_unused, bfifo_full_unused, rlast_unused;
  logic                      xfer, at_last, at_idx_max, beat_consume;
  logic [31:0]               sel_base;

  fifo_simple #(.AWIDTH(BUF_CFG_AWIDTH), .DWIDTH(CFG_DWIDTH)) u_cmd_fifo (
    .clk(clk), .rst(rst),
    .wr_en_i(cfg_val), .wr_data_i(cfg_length),
    .rd_en_i(cmd_pop), .rd_data_o(cmd_data),
    .empty_o(cmd_empty), .full_o(cmd_full), .almost_full_o(cmd_afull_unused)
  );

  // rready is gated on almost-full, so a beat offered in the cycle the
  // FIFO fills can never be dropped by the full check inside the FIFO.
  fifo_simple #(.AWIDTH(BUF_AWIDTH), .DWIDTH(AXI_DATA_WIDTH + 1)) u_beat_fifo (
    .clk(clk), .rst(rst),
    .wr_en_i(axi_rvalid & axi_rready), .wr_data_i({axi_rlast, axi_rdata}),
    .rd_en_i(bfifo_pop), .rd_data_o(bfifo_data),
    .empty_o(bfifo_empty), .full_o(bfifo_full_unused), .almost_full_o(bfifo_afull)
  );

  assign rlast_unused = bfifo_data[AXI_DATA_WIDTH];

  assign cfg_rdy    = ~cmd_full;
  assign axi_rready = ~bfifo_afull;
  assign cmd_pop    = (state_q == S_CONFIG) & ~cmd_empty;

  assign valid      = (state_q == S_ACTIVE) & beat_vld_q;
  assign xfer       = valid & ready;
  assign at_last    = (cnt_q == rem_q);
  assign at_idx_max = (idx_q == IDX_MAX);
  assign last       = valid & at_last;
  assign sel_base   = 32'(idx_q) * DATA_WIDTH;
  assign data       = beat_q[sel_base +: DATA_WIDTH];
  assign done       = done_q;
  assign busy       = (state_q != S_CONFIG);

  // The held beat is released after its top sub-word is sent, or when the
  // flush of a partial final beat reaches the top sub-word.
  assign beat_consume = at_idx_max & (xfer | (state_q == S_FLUSH));
  // Refill the holding register in the same cycle it is released so a
  // continuous stream runs at one word per cycle.
  assign bfifo_pop    = ~bfifo_empty & (~beat_vld_q | beat_consume);

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q     <= '0;
      beat_vld_q <= 1'b0;
    end else if (bfifo_pop) begin
      beat_q     <= bfifo_data[AXI_DATA_WIDTH-1:0];
      beat_vld_q <= 1'b1;
    end else if (beat_consume) begin
      beat_vld_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CONFIG;
      len_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_CONFIG: begin
          if (!cmd_empty) begin
            len_q   <= cmd_data;
            state_q <= S_SET;
          end
        end
        S_SET: begin
          rem_q <= len_q - CFG_DWIDTH'(1);
          cnt_q <= '0;
          idx_q <= '0;
          if (len_q == '0) begin
            done_q  <= 1'b1;
            state_q <= S_CONFIG;
          end else begin
            state_q <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (xfer) begin
            cnt_q <= cnt_q + CFG_DWIDTH'(1);
            idx_q <= at_idx_max ? '0 : idx_q + IDX_W'(1);
            if (at_last) begin
              if (at_idx_max) begin
                done_q  <= 1'b1;
                state_q <= S_CONFIG;
              end else begin
                state_q <= S_FLUSH;
              end
            end
          end
        end
        S_FLUSH: begin
          if (at_idx_max) begin
            idx_q   <= '0;
            done_q  <= 1'b1;
            state_q <= S_CONFIG;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: state_q <= S_CONFIG;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_read_stream.sv
// tb/tb_axis_read_stream.sv - randomized self-checking bench for axis_read_stream
module tb_axis_read_stream;
  localparam int DW = 32;
  localparam int R  = 2;
  localparam int AW = 64;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] cfg_length;
  logic          cfg_val;
  logic          cfg_rdy;
  logic [AW-1:0] axi_rdata;
  logic          axi_rlast;
  logic          axi_rvalid;
  logic          axi_rready;
  logic [DW-1:0] data;
  logic          last;
  logic          valid;
  logic          ready = 1'b0;
  logic          done;
  logic          busy;

  always #5 clk = ~clk;

  axis_read_stream #(
    .BUF_CFG_AWIDTH(5), .BUF_AWIDTH(9), .CFG_DWIDTH(CW),
    .DATA_WIDTH(DW), .WIDTH_RATIO(R), .AXI_DATA_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_length(cfg_length), .cfg_val(cfg_val), .cfg_rdy(cfg_rdy),
    .axi_rdata(axi_rdata), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .data(data), .last(last), .valid(valid), .ready(ready),
    .done(done), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: commands, the beats they need, and the words they must produce.
  logic [CW-1:0] cmd_q[$];
  logic [AW-1:0] beat_q[$];
  logic [AW-1:0] fixed_q[$];
  logic [DW:0]   exp_q[$];
  int exp_done = 0, got_done = 0, n_xfer = 0, acc_beats = 0;
  int ready_pct = 100, valid_pct = 100;
  logic saw_full = 1'b0;

  // A stream of len words uses ceil(len/R) beats; the unused tail of the
  // last beat is discarded, and a zero-length stream uses no beat at all.
  task automatic add_cmd(input int len);
    logic [AW-1:0] b;
    b = '0;
    cmd_q.push_back(CW'(len));
    for (int i = 0; i < len; i++) begin
      if (i % R == 0) begin
        if (fixed_q.size() > 0) b = fixed_q.pop_front();
        else b = {$urandom, $urandom};
        beat_q.push_back(b);
      end
      exp_q.push_back({(i == len - 1), b[(i % R) * DW +: DW]});
    end
    exp_done++;
  endtask

  initial begin : cfg_drv
    logic acc;
    cfg_val = 1'b0;
    cfg_length = '0;
    forever begin
      @(negedge clk);
      acc = cfg_val & cfg_rdy;
      @(posedge clk);
      #1;
      if (acc && cmd_q.size() > 0) cmd_q.delete(0);
      cfg_val = (cmd_q.size() > 0) && !rst;
      if (cmd_q.size() > 0) cfg_length = cmd_q[0];
    end
  end

  initial begin : axi_drv
    logic acc;
    axi_rvalid = 1'b0;
    axi_rdata = '0;
    axi_rlast = 1'b0;
    forever begin
      @(negedge clk);
      acc = axi_rvalid & axi_rready;
      @(posedge clk);
      #1;
      if (acc && beat_q.size() > 0) begin
        beat_q.delete(0);
        acc_beats++;
      end
      axi_rvalid = (beat_q.size() > 0) && !rst && ($urandom_range(99) < valid_pct);
      if (beat_q.size() > 0) axi_rdata = beat_q[0];
      axi_rlast = 1'($urandom_range(1));
    end
  end

  initial begin : rdy_drv
    forever begin
      @(posedge clk);
      #1;
      ready = ($urandom_range(99) < ready_pct);
    end
  end

  initial begin : mon
    logic pv, pr, pl;
    logic [DW-1:0] pd;
    logic [DW:0] e;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pv && !pr) begin
          check("stall_valid", valid, 1);
          check("stall_data", data, pd);
          check("stall_last", last, pl);
        end
        if (valid && ready) begin
          n_xfer++;
          if (exp_q.size() == 0) check("unexpected_word", exp_q.size(), 1);
          else begin
            e = exp_q.pop_front();
            check("word", {last, data}, e);
          end
        end
        if (done) got_done++;
        if (!axi_rready) saw_full = 1'b1;
        pv = valid; pr = ready; pd = data; pl = last;
      end else begin
        pv = 1'b0;
      end
    end
  end

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || cmd_q.size() > 0 || got_done < exp_done) && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (6) @(posedge clk);
    check({tag, "_timeout"}, (n < budget), 1);
    check({tag, "_words_left"}, exp_q.size(), 0);
    check({tag, "_done_count"}, got_done, exp_done);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_last"}, last, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cfg_rdy"}, cfg_rdy, 1);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n0, n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    check("reset_axi_rready", axi_rready, 1);
    rst = 1'b0;
    ready_pct = 100;

    // T1: two beats, one four-word stream
    fixed_q.push_back(64'h00000001_00000000);
    fixed_q.push_back(64'h00000003_00000002);
    add_cmd(4);
    wait_drain("t1", 200);

    // T2: odd-length stream forces a flush of word 3
    fixed_q.push_back(64'h00000001_00000000);
    fixed_q.push_back(64'h00000003_00000002);
    fixed_q.push_back(64'h00000005_00000004);
    add_cmd(3);
    add_cmd(2);
    wait_drain("t2", 300);

    // T3: zero-length command, then a one-word command
    add_cmd(0);
    add_cmd(1);
    wait_drain("t3", 200);

    // T4: long stream and a random mix under random backpressure
    ready_pct = 50;
    valid_pct = 70;
    add_cmd(64);
    for (int i = 0; i < 8; i++) add_cmd($urandom_range(20));
    wait_drain("t4", 3000);

    // T5: fill the beat buffer with the output stalled
    ready_pct = 0;
    valid_pct = 100;
    repeat (2) @(posedge clk);
    saw_full = 1'b0;
    acc_beats = 0;
    n0 = n_xfer;
    add_cmd(1200);
    n = 0;
    while (!saw_full && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (20) @(posedge clk);
    check("t5_rready_fell", saw_full, 1);
    check("t5_no_output", n_xfer - n0, 0);
    check("t5_fill_level", (acc_beats >= 500 && acc_beats <= 512), 1);
    check("t5_backlog", (beat_q.size() >= 80), 1);
    ready_pct = 100;
    wait_drain("t5", 5000);

    // T6: reset in the middle of a ten-word stream
    ready_pct = 100;
    n0 = n_xfer;
    add_cmd(10);
    n = 0;
    while (n_xfer < n0 + 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach_word5", (n < 200), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    cmd_q.delete();
    beat_q.delete();
    exp_q.delete();
    cfg_val = 1'b0;
    axi_rvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle("t6_after_rst");
    rst = 1'b0;
    got_done = 0;
    exp_done = 0;
    add_cmd(2);
    wait_drain("t6", 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
